// File: rtl/risky2_uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// The state enum, parity mode codes and baud divider live here so every file agrees on them.
package risky2_uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_tx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is always visible on o_head while not empty.
// Occupancy is tracked by its own counter, so full and empty never depend on comparing pointers.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Full is the pre-edge value, so a push into a full FIFO is dropped even if a pop happens too
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rdPtr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of outgoing words feeding a frame serialiser with
// optional parity and one or two stop bits, plus polling status and a sticky overflow flag.
module uart_tx_fifo
   import risky2_uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD        = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int DEPTH       = 16,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_BITS-1:0]       wr_data,
   input  logic                       ovf_clr,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy,
   output logic                       overflow,
   output logic                       uart_tx
);

   localparam int DIV   = baud_div(CLK_FREQ_HZ, BAUD);
   localparam int CNT_W = $clog2(STOP_BITS * DIV + 1);
   localparam int IDX_W = 4;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS * DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

   if (DIV < 2) begin : g_divCheck
      $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bitsCheck
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
   end

   uart_tx_state_e       r_state;
   logic [CNT_W-1:0]     r_baudCnt;
   logic [IDX_W-1:0]     r_bitIdx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;
   logic                 r_overflow;
   logic [DATA_BITS-1:0] w_head;
   logic                 w_bitDone;
   logic                 w_pop;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (wr_en),
      .i_data  (wr_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (full),
      .o_empty (empty),
      .o_count (count)
   );

   // Popping at the end of the stop bits lets the next start bit follow with no idle gap
   assign w_bitDone = (r_baudCnt == '0);
   assign w_pop     = !empty && ((r_state == IDLE) || (r_state == STOP && w_bitDone));
   assign busy      = (r_state != IDLE);
   assign overflow  = r_overflow;
   assign uart_tx   = r_tx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_baudCnt <= '0;
         r_bitIdx  <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift   <= w_head;
                  r_parity  <= (^w_head) ^ (PARITY == PARITY_ODD);
                  r_baudCnt <= LAST_BIT;
                  r_tx      <= 1'b0;
                  r_state   <= START;
               end
            end
            START: begin
               if (w_bitDone) begin
                  r_state   <= DATA;
                  r_tx      <= r_shift[0];
                  r_bitIdx  <= '0;
                  r_baudCnt <= LAST_BIT;
               end else begin
                  r_baudCnt <= r_baudCnt - 1'b1;
               end
            end
            DATA: begin
               if (w_bitDone) begin
                  r_baudCnt <= LAST_BIT;
                  if (r_bitIdx == LAST_IDX) begin
                     if (PARITY != PARITY_NONE) begin
                        r_state <= PAR;
                        r_tx    <= r_parity;
                     end else begin
                        r_state   <= STOP;
                        r_tx      <= 1'b1;
                        r_baudCnt <= LAST_STOP;
                     end
                  end else begin
                     r_shift  <= r_shift >> 1;
                     r_tx     <= r_shift[1];
                     r_bitIdx <= r_bitIdx + 1'b1;
                  end
               end else begin
                  r_baudCnt <= r_baudCnt - 1'b1;
               end
            end
            PAR: begin
               if (w_bitDone) begin
                  r_state   <= STOP;
                  r_tx      <= 1'b1;
                  r_baudCnt <= LAST_STOP;
               end else begin
                  r_baudCnt <= r_baudCnt - 1'b1;
               end
            end
            STOP: begin
               if (w_bitDone) begin
                  if (w_pop) begin
                     r_shift   <= w_head;
                     r_parity  <= (^w_head) ^ (PARITY == PARITY_ODD);
                     r_baudCnt <= LAST_BIT;
                     r_tx      <= 1'b0;
                     r_state   <= START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_baudCnt <= r_baudCnt - 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // A dropped push in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (wr_en && full) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

endmodule
